// File: rtl/whirlpool_wcipher_pi_inv.sv
// Row-streaming Whirlpool W-cipher Pi / inverse Pi with ping-pong row banks.
// Column j rotates up by j rows (inverse) or down by j rows (forward).
module whirlpool_wcipher_pi_inv #(
  parameter bit FWD = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_row,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_row,
  output logic        out_last,
  output logic        busy
);

  logic [63:0] mem_q [2][8];

  logic       wr_bank_q, wr_bank_d;
  logic [2:0] wr_row_q, wr_row_d;
  logic       rd_bank_q, rd_bank_d;
  logic [2:0] rd_row_q, rd_row_d;
  logic [1:0] full_q, full_d;

  logic        wr_en;
  logic        rd_en;
  logic [63:0] col_row;

  // clr blocks both interfaces so nothing moves while pointers reset
  assign in_ready  = ~full_q[wr_bank_q] & ~clr;
  assign out_valid = full_q[rd_bank_q] & ~clr;
  assign out_last  = out_valid & (rd_row_q == 3'd7);
  assign busy      = (|full_q) | (wr_row_q != 3'd0);

  assign wr_en = in_valid & in_ready;
  assign rd_en = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_row_q] <= in_row;
    end
  end

  for (genvar j = 0; j < 8; j++) begin : g_col
    logic [2:0] sel;
    if (FWD) begin : g_fwd
      assign sel = rd_row_q - 3'(j);
    end else begin : g_inv
      assign sel = rd_row_q + 3'(j);
    end
    assign col_row[63-8*j -: 8] =
      mem_q[rd_bank_q][sel][63-8*j -: 8];
  end

  assign out_row = out_valid ? col_row : '0;

  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_row_d  = rd_row_q;
    full_d    = full_q;
    if (clr) begin
      wr_bank_d = 1'b0;
      wr_row_d  = 3'd0;
      rd_bank_d = 1'b0;
      rd_row_d  = 3'd0;
      full_d    = 2'b00;
    end else begin
      if (wr_en) begin
        wr_row_d = wr_row_q + 3'd1;
        if (wr_row_q == 3'd7) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d = ~wr_bank_q;
        end
      end
      // read and write banks differ whenever both complete together
      if (rd_en) begin
        rd_row_d = rd_row_q + 3'd1;
        if (rd_row_q == 3'd7) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d = ~rd_bank_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_bank_q <= 1'b0;
      rd_row_q  <= 3'd0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_row_q  <= rd_row_d;
      full_q    <= full_d;
    end
  end

endmodule

// File: tb/tb_whirlpool_wcipher_pi_inv.sv
// Scoreboard bench: inverse and forward instances driven by one stream,
// expected rows pushed per block, popped by an independent monitor.
module tb_whirlpool_wcipher_pi_inv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clr, in_valid, out_ready;
  logic [63:0] in_row;
  logic        in_ready_i, in_ready_f;
  logic        ov_i, ov_f, ol_i, ol_f, busy_i, busy_f;
  logic [63:0] or_i, or_f;

  whirlpool_wcipher_pi_inv #(.FWD(1'b0)) u_inv (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_i),
    .in_row(in_row), .out_valid(ov_i),
    .out_ready(out_ready), .out_row(or_i),
    .out_last(ol_i), .busy(busy_i)
  );

  whirlpool_wcipher_pi_inv #(.FWD(1'b1)) u_fwd (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_f),
    .in_row(in_row), .out_valid(ov_f),
    .out_ready(out_ready), .out_row(or_f),
    .out_last(ol_f), .busy(busy_f)
  );

  typedef logic [63:0] blk_t [8];

  logic        ov [2];
  logic        ol [2];
  logic [63:0] orow [2];
  assign ov[0] = ov_i;
  assign ov[1] = ov_f;
  assign ol[0] = ol_i;
  assign ol[1] = ol_f;
  assign orow[0] = or_i;
  assign orow[1] = or_f;

  logic [64:0] sb [2][$];
  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 1;
  bit          holding = 0;
  logic [63:0] held;
  blk_t        cur;
  int          wr_n = 0;
  bit          vec_blk = 0;
  int          stalls = 0;

  task automatic chk(input string nm, input logic [64:0] act,
                     input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // B[i][j] = A[(i+j)%8][j] inverse, A[(i-j)%8][j] forward
  function automatic logic [63:0] pi_row(input blk_t a, input int i,
                                         input bit fwd);
    logic [63:0] r;
    int src;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      src = fwd ? (i - j + 8) % 8 : (i + j) % 8;
      r[63-8*j -: 8] = a[src][63-8*j -: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] vec_row(input int i);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[63-8*j -: 8] = {4'(i), 4'(j)};
    return r;
  endfunction

  task automatic push_block();
    logic [63:0] e;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        e = pi_row(cur, i, k == 1);
        if (vec_blk) begin
          if (k == 0 && i == 0) e = 64'h0011223344556677;
          if (k == 0 && i == 1) e = 64'h1021324354657607;
          if (k == 0 && i == 7) e = 64'h7001122334455667;
          if (k == 1 && i == 0) e = 64'h0071625344352617;
          if (k == 1 && i == 1) e = 64'h1001726354453627;
        end
        sb[k].push_back({i == 7, e});
      end
    end
  endtask

  task automatic flush();
    sb[0].delete();
    sb[1].delete();
    wr_n = 0;
    holding = 0;
  endtask

  // called at a negedge; returns at the negedge after the accept
  task automatic send_row(input logic [63:0] r);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_row = r;
    while (!(in_ready_i && in_ready_f) && n <= 300) begin
      @(negedge clk);
      n++;
    end
    if (n > 300) begin
      total++;
      bad++;
      $display("FAIL in_timeout: got in_ready=0 want 1");
      in_valid = 1'b0;
      return;
    end
    stalls += n;
    @(posedge clk);
    cur[wr_n] = r;
    wr_n++;
    if (wr_n == 8) begin
      push_block();
      wr_n = 0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    rdy_mode = 1;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 65'(sb[0].size() + sb[1].size()), 65'd0);
    @(negedge clk);
    chk({nm, "_ov"}, 65'({ov_i, ov_f}), 65'd0);
  endtask

  task automatic pulse_clr(input string nm);
    clr = 1'b1;
    #1;
    flush();
    chk({nm, "_rdy_during"}, 65'(in_ready_i), 65'd0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk({nm, "_busy"}, 65'({busy_i, busy_f}), 65'd0);
    chk({nm, "_ov"}, 65'({ov_i, ov_f}), 65'd0);
    chk({nm, "_rdy"}, 65'({in_ready_i, in_ready_f}), 65'd3);
  endtask

  initial begin
    logic [64:0] e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n || clr) begin
        holding = 0;
        continue;
      end
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      if (holding) chk("hold_row", 65'(or_i), 65'(held));
      for (int k = 0; k < 2; k++) begin
        if (ov[k]) begin
          if (out_ready) begin
            if (sb[k].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_out%0d: got %h want none",
                       k, orow[k]);
            end else begin
              e = sb[k].pop_front();
              chk(k == 0 ? "out_inv" : "out_fwd",
                  {ol[k], orow[k]}, e);
            end
          end
        end else begin
          chk("idle_zero", {ol[k], orow[k]}, 65'd0);
        end
      end
      holding = ov_i && !out_ready;
      held = or_i;
    end
  end

  initial begin
    reset_n = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    in_row = '0;
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 65'({in_ready_i, in_ready_f}), 65'd3);
    chk("rst_out_valid", 65'({ov_i, ov_f}), 65'd0);
    chk("rst_out_row", 65'(or_i | or_f), 65'd0);
    chk("rst_out_last", 65'({ol_i, ol_f}), 65'd0);
    chk("rst_busy", 65'({busy_i, busy_f}), 65'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // reference vector, no stalls
    vec_blk = 1;
    stalls = 0;
    for (int i = 0; i < 8; i++) send_row(vec_row(i));
    vec_blk = 0;
    chk("t1_no_stall", 65'(stalls), 65'd0);
    chk("t1_latency", 65'({ov_i, ov_f}), 65'd3);
    repeat (8) @(negedge clk);
    chk("t1_drained", 65'({ov_i, busy_i}), 65'd0);
    chk("t1_sb_empty", 65'(sb[0].size() + sb[1].size()), 65'd0);

    // sink stalled while two blocks load
    rdy_mode = 2;
    for (int i = 0; i < 16; i++) send_row({$urandom, $urandom});
    chk("t4_in_ready_low", 65'({in_ready_i, in_ready_f}), 65'd0);
    chk("t4_busy", 65'({busy_i, busy_f}), 65'd3);
    in_valid = 1'b1;
    in_row = {$urandom, $urandom};
    @(negedge clk);
    chk("t4_17th_blocked", 65'(in_ready_i), 65'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rdy_mode = 1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("t4_rdy_before", 65'(in_ready_i), 65'd0);
    @(negedge clk);
    chk("t4_rdy_after", 65'(in_ready_i), 65'd1);
    repeat (12) @(negedge clk);
    chk("t4_sb_empty", 65'(sb[0].size() + sb[1].size()), 65'd0);

    // async reset while loading row 4 of block 1
    rdy_mode = 0;
    for (int i = 0; i < 12; i++) send_row({$urandom, $urandom});
    in_valid = 1'b1;
    in_row = {$urandom, $urandom};
    #2 reset_n = 1'b0;
    #1;
    flush();
    chk("t5_in_ready", 65'({in_ready_i, in_ready_f}), 65'd3);
    chk("t5_out_valid", 65'({ov_i, ov_f}), 65'd0);
    chk("t5_out_row", 65'(or_i | or_f), 65'd0);
    chk("t5_out_last", 65'({ol_i, ol_f}), 65'd0);
    chk("t5_busy", 65'({busy_i, busy_f}), 65'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) send_row({$urandom, $urandom});
    drain("t5_drain");

    // clr with bank 0 full and three rows into bank 1
    pulse_clr("clr_a");
    rdy_mode = 2;
    for (int i = 0; i < 11; i++) send_row({$urandom, $urandom});
    chk("t6_pre_busy", 65'(busy_i), 65'd1);
    pulse_clr("t6");
    for (int i = 0; i < 8; i++) send_row({$urandom, $urandom});
    drain("t6_drain");

    // random traffic with gaps and sink backpressure
    rdy_mode = 0;
    for (int b = 0; b < 100; b++) begin
      for (int r = 0; r < 8; r++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_row({$urandom, $urandom});
      end
    end
    drain("rand_drain");
    chk("end_busy", 65'({busy_i, busy_f}), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
